mem_responder256: RTL and testbench

MEM_RESPONDER256 -- requirements
Module: mem_responder256

---
 rtl/mem_responder256_if.sv | 24 ++
 rtl/mem_responder256.sv | 102 ++++++++++
 tb/tb_mem_responder256.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder256_if.sv
// Request/response bundle for mem_responder256: a level request in, a one-cycle
// completion strobe and registered read data out.
interface mem_responder256_if;
   // Handshake: a request (read_mem/write_mem with addr/in_bus) is taken on any
   // rising edge where the responder is idle; rdyMem is high for exactly one
   // cycle when it completes, and busy covers the span in between.
   logic        read_mem;
   logic        write_mem;
   logic [7:0]  addr;
   logic [15:0] in_bus;
   logic        rdyMem;
   logic [15:0] out_bus;
   logic        busy;

   modport master (
      output read_mem, write_mem, addr, in_bus,
      input  rdyMem, out_bus, busy
   );

   modport slave (
      input  read_mem, write_mem, addr, in_bus,
      output rdyMem, out_bus, busy
   );
endinterface

// File: rtl/mem_responder256.sv
// 256 x 16 memory with a fixed, parameterised response latency and a
// one-cycle completion strobe; array resets to word i = 255-i.
module mem_responder256 #(
   parameter int unsigned LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   mem_responder256_if.slave  bus,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [7:0]  lat_addr;
   logic [15:0] lat_data;
   logic        lat_wr;
   logic [15:0] out_q;
   logic [15:0] mem [256];

   logic        req;
   logic        accept;
   logic        enter_ready;
   logic [7:0]  eff_addr;
   logic [15:0] eff_data;
   logic        eff_wr;

   assign req    = bus.read_mem | bus.write_mem;
   assign accept = (state == IDLE) && req;

   // With LATENCY=1 the array is touched on the accepting edge itself, so the
   // live inputs stand in for the not-yet-latched copies.
   assign eff_addr = (state == IDLE) ? bus.addr      : lat_addr;
   assign eff_data = (state == IDLE) ? bus.in_bus    : lat_data;
   assign eff_wr   = (state == IDLE) ? bus.write_mem : lat_wr;

   assign enter_ready = (state_nx == READY) && (state != READY);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = (LATENCY == 1) ? READY : BUSY;
         BUSY:    if (cnt == 4'd1) state_nx = READY;
         READY:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.rdyMem = (state == READY);
      bus.busy   = (state != IDLE);
      state_dbg  = state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 4'd0;
         lat_addr <= 8'd0;
         lat_data <= 16'd0;
         lat_wr   <= 1'b0;
      end else if (accept) begin
         cnt      <= LAT_M1;
         lat_addr <= bus.addr;
         lat_data <= bus.in_bus;
         lat_wr   <= bus.write_mem;
      end else if (state == BUSY) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Write wins over read when both are requested together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'(255 - i);
      end else if (enter_ready && eff_wr) begin
         mem[eff_addr] <= eff_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         out_q <= 16'h0000;
      else if (enter_ready && !eff_wr) out_q <= mem[eff_addr];
   end

   assign bus.out_bus = out_q;

endmodule

// File: tb/tb_mem_responder256.sv
// Directed bench for mem_responder256: a LATENCY=2 instance for the main
// sequences and a LATENCY=1 instance for back-to-back held requests.
module tb_mem_responder256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state_dbg0, state_dbg1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];

  mem_responder256_if bus0 ();
  mem_responder256_if bus1 ();

  mem_responder256 #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(state_dbg0)
  );

  mem_responder256 #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state_dbg1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus0.rdyMem) begin
      if (exp_q.size() == 0) begin
        chk("u0_unexpected_rdy", 32'd1, 32'd0);
      end else begin
        chk("u0_out_bus", {16'h0, bus0.out_bus}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.rdyMem) begin
      if (exp1_q.size() == 0) begin
        chk("u1_unexpected_rdy", 32'd1, 32'd0);
      end else begin
        chk("u1_out_bus", {16'h0, bus1.out_bus}, {16'h0, exp1_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rdy",   {31'h0, bus0.rdyMem}, 32'd0);
    chk("rst_busy",  {31'h0, bus0.busy},   32'd0);
    chk("rst_out",   {16'h0, bus0.out_bus}, 32'h0000);
    chk("rst_state", {30'h0, state_dbg0},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request on u0; mess scrambles addr/in_bus while the request is in flight.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp, input bit mess);
    int n;
    exp_q.push_back(exp);
    @(negedge clk);
    bus0.read_mem  = rd;
    bus0.write_mem = wr;
    bus0.addr      = a;
    bus0.in_bus    = d;
    @(negedge clk);
    chk("busy_after_accept", {31'h0, bus0.busy}, 32'd1);
    bus0.read_mem  = 1'b0;
    bus0.write_mem = 1'b0;
    if (mess) begin
      bus0.addr   = a + 8'd1;
      bus0.in_bus = 16'h9999;
    end
    n = 1;
    while (!bus0.rdyMem && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency_edges", n, 32'd2);
    chk("busy_in_ready", {31'h0, bus0.busy}, 32'd1);
    @(negedge clk);
    chk("rdy_one_cycle", {31'h0, bus0.rdyMem}, 32'd0);
    chk("busy_cleared",  {31'h0, bus0.busy},   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus0.read_mem = 1'b0; bus0.write_mem = 1'b0; bus0.addr = 8'h00; bus0.in_bus = 16'h0;
    bus1.read_mem = 1'b0; bus1.write_mem = 1'b0; bus1.addr = 8'h00; bus1.in_bus = 16'h0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("init_rdy",  {31'h0, bus0.rdyMem},  32'd0);
    chk("init_busy", {31'h0, bus0.busy},    32'd0);
    chk("init_out",  {16'h0, bus0.out_bus}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Read of word 0 after reset.
    do_req(1'b1, 1'b0, 8'h00, 16'h0000, 16'h00FF, 1'b0);

    // Write then read-back from a fresh reset; write leaves out_bus alone.
    do_reset();
    do_req(1'b0, 1'b1, 8'h7F, 16'hABCD, 16'h0000, 1'b0);
    do_req(1'b1, 1'b0, 8'h7F, 16'h0000, 16'hABCD, 1'b0);

    // Read+write together performs the write only.
    do_req(1'b1, 1'b1, 8'h10, 16'h1234, 16'hABCD, 1'b0);
    do_req(1'b1, 1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0);

    // Inputs scrambled mid-request: latched request wins, neighbour untouched.
    do_req(1'b0, 1'b1, 8'h20, 16'h5555, 16'h1234, 1'b1);
    do_req(1'b1, 1'b0, 8'h20, 16'h0000, 16'h5555, 1'b0);
    do_req(1'b1, 1'b0, 8'h21, 16'h0000, 16'h00DE, 1'b0);

    // Reset during BUSY aborts the write with no strobe.
    @(negedge clk);
    bus0.write_mem = 1'b1; bus0.addr = 8'h05; bus0.in_bus = 16'hBEEF;
    @(negedge clk);
    bus0.write_mem = 1'b0;
    chk("abort_busy", {31'h0, bus0.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rdy",   {31'h0, bus0.rdyMem}, 32'd0);
    chk("abort_busy0", {31'h0, bus0.busy},   32'd0);
    chk("abort_out",   {16'h0, bus0.out_bus}, 32'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, 1'b0, 8'h05, 16'h0000, 16'h00FA, 1'b0);

    // Address extremes are independent locations.
    do_req(1'b0, 1'b1, 8'hFF, 16'hCAFE, 16'h00FA, 1'b0);
    do_req(1'b1, 1'b0, 8'h00, 16'h0000, 16'h00FF, 1'b0);
    do_req(1'b1, 1'b0, 8'hFF, 16'h0000, 16'hCAFE, 1'b0);

    // LATENCY=1: held read of word 255 strobes every other cycle.
    for (int i = 0; i < 4; i++) exp1_q.push_back(16'h0000);
    @(negedge clk);
    bus1.read_mem = 1'b1; bus1.addr = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("l1_rdy_pattern", {31'h0, bus1.rdyMem}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus1.read_mem = 1'b0;

    // LATENCY=1 write takes effect on the accepting edge.
    exp1_q.push_back(16'h0000);
    @(negedge clk);
    bus1.write_mem = 1'b1; bus1.addr = 8'hFF; bus1.in_bus = 16'h1111;
    @(negedge clk);
    bus1.write_mem = 1'b0;
    chk("l1_wr_rdy", {31'h0, bus1.rdyMem}, 32'd1);
    exp1_q.push_back(16'h1111);
    @(negedge clk);
    bus1.read_mem = 1'b1;
    @(negedge clk);
    bus1.read_mem = 1'b0;
    chk("l1_rd_rdy", {31'h0, bus1.rdyMem}, 32'd1);

    repeat (4) @(negedge clk);
    chk("u0_queue_drained", exp_q.size(),  32'd0);
    chk("u1_queue_drained", exp1_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog keeps the run bounded whatever the DUT does.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
